// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle MIPS PC sequencer (FETCH/DECODE/UPDATE), optional target check under PC_ALIGN_CHECK_EN
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_ack,
    input  logic        dec_valid,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic        is_jump,
    input  logic        is_jr,
    input  logic        exc_req,
    input  logic [31:0] pc_next,
    output logic [2:0]  pc_source,
    output logic [31:0] pc,
    output logic        pc_write,
    output logic        fetch_req,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause
);
    localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (FETCH_TIMEOUT != 0);

    localparam logic [2:0] SRC_SEQ  = 3'd0;
    localparam logic [2:0] SRC_BR   = 3'd1;
    localparam logic [2:0] SRC_JMP  = 3'd2;
    localparam logic [2:0] SRC_REG  = 3'd3;
    localparam logic [2:0] SRC_EXC  = 3'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_INSTR   = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   pc_q;
    logic [31:0]   epc_q;
    logic [2:0]    src_q;
    logic [1:0]    cause_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            src_q   <= SRC_SEQ;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // An ack arriving on the last allowed cycle still wins over the timeout.
                    if (fetch_ack) begin
                        cnt_q   <= '0;
                        state_q <= ST_DECODE;
                    end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        src_q   <= SRC_EXC;
                        epc_q   <= pc_q;
                        cause_q <= CAUSE_TIMEOUT;
                        state_q <= ST_UPDATE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DECODE: begin
                    if (dec_valid) begin
                        if (exc_req) begin
                            src_q   <= SRC_EXC;
                            epc_q   <= pc_q;
                            cause_q <= CAUSE_INSTR;
                        end else if (is_jr) begin
                            src_q <= SRC_REG;
                        end else if (is_jump) begin
                            src_q <= SRC_JMP;
                        end else if (is_branch && branch_taken) begin
                            src_q <= SRC_BR;
                        end else begin
                            src_q <= SRC_SEQ;
                        end
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
`ifdef PC_ALIGN_CHECK_EN
                    // Exception-vector loads skip the check so a bad vector cannot recurse.
                    if (src_q != SRC_EXC && pc_next[1:0] != 2'b00) begin
                        epc_q   <= pc_q;
                        cause_q <= CAUSE_ALIGN;
                        src_q   <= SRC_EXC;
                    end else begin
                        pc_q    <= pc_next;
                        state_q <= ST_FETCH;
                    end
`else
                    pc_q    <= pc_next;
                    state_q <= ST_FETCH;
`endif
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign fetch_req = (state_q == ST_FETCH) & reset_n;
    assign pc_write  = (state_q == ST_UPDATE);
    assign pc_source = src_q;
    assign pc        = pc_q;
    assign epc       = epc_q;
    assign exc_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized transaction-level check of pc_sequencer
module tb_pc_sequencer;
    localparam logic [31:0] RV      = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h8000_0180;
    localparam int          TO      = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, fetch_ack, dec_valid, is_branch, branch_taken, is_jump, is_jr, exc_req;
    logic [31:0] pc_next;
    logic [2:0]  pc_source;
    logic [31:0] pc, epc;
    logic        pc_write, fetch_req;
    logic [1:0]  exc_cause;

    logic        nt_zero = 1'b0;
    logic [31:0] nt_pcn  = 32'h0;
    logic [2:0]  nt_pc_source;
    logic [31:0] nt_pc, nt_epc;
    logic        nt_pc_write, nt_fetch_req;
    logic [1:0]  nt_exc_cause;

    pc_sequencer #(.RESET_VECTOR(RV), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_ack(fetch_ack), .dec_valid(dec_valid),
        .is_branch(is_branch), .branch_taken(branch_taken), .is_jump(is_jump), .is_jr(is_jr),
        .exc_req(exc_req), .pc_next(pc_next), .pc_source(pc_source), .pc(pc),
        .pc_write(pc_write), .fetch_req(fetch_req), .epc(epc), .exc_cause(exc_cause)
    );

    pc_sequencer #(.RESET_VECTOR(RV), .FETCH_TIMEOUT(0)) dut_nt (
        .clk(clk), .reset_n(reset_n), .fetch_ack(nt_zero), .dec_valid(nt_zero),
        .is_branch(nt_zero), .branch_taken(nt_zero), .is_jump(nt_zero), .is_jr(nt_zero),
        .exc_req(nt_zero), .pc_next(nt_pcn), .pc_source(nt_pc_source), .pc(nt_pc),
        .pc_write(nt_pc_write), .fetch_req(nt_fetch_req), .epc(nt_epc), .exc_cause(nt_exc_cause)
    );

    int n_chk = 0;
    int n_fail = 0;
    int nt_bad = 0;
    int nt_streak = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    logic [2:0]  m_src;
    logic [31:0] exp_pc, exp_epc;
    logic [1:0]  exp_cause;
    logic [2:0]  exp_src;
    logic        exp_pw, exp_fr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                check("pc", pc, exp_pc);
                check("epc", epc, exp_epc);
                check("exc_cause", 32'(exc_cause), 32'(exp_cause));
                check("pc_source", 32'(pc_source), 32'(exp_src));
                check("pc_write", 32'(pc_write), 32'(exp_pw));
                check("fetch_req", 32'(fetch_req), 32'(exp_fr));
                if (nt_pc_write !== 1'b0 || nt_fetch_req !== reset_n || nt_pc !== RV ||
                    nt_epc !== 32'h0 || nt_exc_cause !== 2'd0 || nt_pc_source !== 3'd0)
                    nt_bad++;
                if (reset_n) nt_streak++;
                else nt_streak = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        exp_pc = m_pc; exp_epc = m_epc; exp_cause = m_cause; exp_src = m_src;
        @(negedge clk);
    endtask

    task automatic junk_dec();
        dec_valid = 1'($urandom); is_branch = 1'($urandom); branch_taken = 1'($urandom);
        is_jump = 1'($urandom); is_jr = 1'($urandom); exc_req = 1'($urandom);
    endtask

    task automatic model_reset();
        m_pc = RV; m_epc = 32'h0; m_cause = 2'd0; m_src = 3'd0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset_n = 1'b0; fetch_ack = 1'($urandom); junk_dec(); pc_next = $urandom;
            exp_fr = 1'b0; exp_pw = 1'b0;
            step();
            model_reset();
        end
        reset_n = 1'b1;
    endtask

    // fl = {exc_req, is_jr, is_jump, is_branch, branch_taken}
    task automatic do_instr(input int ack_wait, input int dec_wait, input logic [4:0] fl,
                            input logic [31:0] tgt);
        bit to_hit = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            fetch_ack = (k == ack_wait); junk_dec(); pc_next = $urandom;
            exp_fr = 1'b1; exp_pw = 1'b0;
            step();
            if (k == ack_wait) break;
            if (k == TO - 1) begin
                to_hit = 1'b1; m_src = 3'd4; m_epc = m_pc; m_cause = 2'd3;
                break;
            end
        end
        if (!to_hit) begin
            for (int d = 0; d <= dec_wait; d++) begin
                fetch_ack = 1'($urandom); pc_next = $urandom; junk_dec();
                if (d == dec_wait) begin
                    dec_valid = 1'b1;
                    {exc_req, is_jr, is_jump, is_branch, branch_taken} = fl;
                end else begin
                    dec_valid = 1'b0;
                end
                exp_fr = 1'b0; exp_pw = 1'b0;
                step();
            end
            if (fl[4]) begin m_src = 3'd4; m_epc = m_pc; m_cause = 2'd1; end
            else if (fl[3]) m_src = 3'd3;
            else if (fl[2]) m_src = 3'd2;
            else if (fl[1] && fl[0]) m_src = 3'd1;
            else m_src = 3'd0;
        end
        fetch_ack = 1'($urandom); junk_dec(); pc_next = tgt;
        exp_fr = 1'b0; exp_pw = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        if (m_src != 3'd4 && tgt[1:0] != 2'b00) begin
            step();
            m_epc = m_pc; m_cause = 2'd2; m_src = 3'd4;
            fetch_ack = 1'($urandom); junk_dec(); pc_next = EXC_VEC;
            step();
            m_pc = EXC_VEC;
        end else begin
            step();
            m_pc = tgt;
        end
`else
        step();
        m_pc = tgt;
`endif
    endtask

    initial begin
        int aw, dw, r;
        logic [4:0]  fl;
        logic [31:0] tgt;
        reset_n = 1'b0; fetch_ack = 1'b0; dec_valid = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        is_jump = 1'b0; is_jr = 1'b0; exc_req = 1'b0; pc_next = 32'h0;
        model_reset(); exp_fr = 1'b0; exp_pw = 1'b0;
        step();
        chk_en = 1'b1;
        do_reset(2);

        do_instr(0, 0, 5'b00000, 32'h4);
        check("t1_pc", pc, 32'h4);
        check("t1_fetch_req", 32'(fetch_req), 32'h1);
        check("t1_src", 32'(pc_source), 32'h0);

        do_instr(0, 0, 5'b00000, 32'h40);
        do_instr(0, 1, 5'b00010, 32'h44);
        check("t2_nt_src", 32'(pc_source), 32'h0);
        do_instr(1, 0, 5'b00011, 32'h80);
        check("t2_tk_src", 32'(pc_source), 32'h1);
        check("t2_tk_pc", pc, 32'h80);

        do_instr(0, 0, 5'b00000, 32'h100);
        do_instr(0, 0, 5'b11100, EXC_VEC);
        check("t3_src", 32'(pc_source), 32'h4);
        check("t3_epc", epc, 32'h100);
        check("t3_cause", 32'(exc_cause), 32'h1);
        check("t3_pc", pc, EXC_VEC);

        do_instr(0, 0, 5'b00000, 32'h300);
        do_instr(1000, 0, 5'b00000, EXC_VEC);
        check("t4_to_cause", 32'(exc_cause), 32'h3);
        check("t4_to_epc", epc, 32'h300);
        check("t4_to_src", 32'(pc_source), 32'h4);
        do_instr(TO - 1, 0, 5'b00000, 32'h304);
        check("t4_late_ack_src", 32'(pc_source), 32'h0);
        check("t4_late_ack_cause", 32'(exc_cause), 32'h3);
        check("t4_late_ack_pc", pc, 32'h304);

        do_instr(0, 0, 5'b00000, 32'h200);
        fetch_ack = 1'b1; junk_dec(); exp_fr = 1'b1; exp_pw = 1'b0;
        step();
        reset_n = 1'b0; dec_valid = 1'b1; exc_req = 1'b1; is_jr = 1'b1; exp_fr = 1'b0;
        step();
        model_reset();
        reset_n = 1'b1;
        #1;
        check("t5_pc", pc, RV);
        check("t5_pc_write", 32'(pc_write), 32'h0);
        check("t5_src", 32'(pc_source), 32'h0);

        do_instr(0, 0, 5'b00000, 32'h100);
        do_instr(0, 0, 5'b01000, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
        check("t6_pc", pc, EXC_VEC);
        check("t6_cause", 32'(exc_cause), 32'h2);
        check("t6_epc", epc, 32'h100);
        check("t6_src", 32'(pc_source), 32'h4);
`else
        check("t6_pc", pc, 32'h102);
        check("t6_cause", 32'(exc_cause), 32'h0);
        check("t6_src", 32'(pc_source), 32'h3);
`endif

        for (int i = 0; i < 2000 && (i < 250 || nt_streak < 1100); i++) begin
            r = $urandom_range(0, 19);
            if (r < 16) aw = r % 4;
            else if (r == 16) aw = TO - 1;
            else aw = 1000;
            dw = $urandom_range(0, 2);
            fl = 5'($urandom);
            if ($urandom_range(0, 3) != 0) fl[4] = 1'b0;
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            do_instr(aw, dw, fl, tgt);
        end

        check("no_timeout_bad_cycles", 32'(nt_bad), 32'h0);
        check("no_timeout_span_1000", 32'(nt_streak >= 1000), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
